// File: rtl/dataram_master.sv
// ============================================================================
// Module      : dataram_master
// Description : Sequencer that converts core byte/bit requests into single-
//               cycle accesses on an internal data RAM port. Bit operations
//               map into the bit-addressable area starting at BIT_BASE.
//               Read-modify-write operations (SETB/CLRB/CPLB/XCHB) are
//               compiled in only when DATARAM_MASTER_RMW_EN is defined;
//               otherwise they complete immediately with err.
// Ports       : clk, rst_n              clock, async active-low reset
//               req, op, addr           core request / opcode / address
//               wdata, wbit             write byte / write bit
//               ack, err, busy, rdata   completion pulse, reject flag,
//                                       busy status, result byte
//               ram_cs_n, ram_rw,       RAM strobe, direction (1 = read),
//               ram_bb                  byte(1)/bit(0) access select
//               ram_addr, ram_pos       RAM byte address, one-hot bit pos
//               ram_din, ram_bin        RAM write byte / write bit
//               ram_dout, ram_bout      RAM read byte / read bit
// Macro       : DATARAM_MASTER_RMW_EN   enables ops 100-111
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataram_master #(
    parameter logic [7:0] BIT_BASE = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       wbit,
    output logic       ack,
    output logic       err,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       ram_cs_n,
    output logic       ram_rw,
    output logic       ram_bb,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_pos,
    output logic [7:0] ram_din,
    output logic       ram_bin,
    input  logic [7:0] ram_dout,
    input  logic       ram_bout
);

    localparam logic [2:0] c_OP_RDB   = 3'b000;
    localparam logic [2:0] c_OP_WRB   = 3'b001;
    localparam logic [2:0] c_OP_RDBIT = 3'b010;
    localparam logic [2:0] c_OP_WRBIT = 3'b011;
    localparam logic [2:0] c_OP_SETB  = 3'b100;
    localparam logic [2:0] c_OP_CLRB  = 3'b101;
    localparam logic [2:0] c_OP_CPLB  = 3'b110;
    localparam logic [2:0] c_OP_XCHB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] op_q;
    logic       ack_q;
    logic       err_q;
    logic       busy_q;
    logic [7:0] rdata_q;
    logic       cs_n_q;
    logic       rw_q;
    logic       bb_q;
    logic [7:0] addr_q;
    logic [7:0] pos_q;
    logic [7:0] din_q;
    logic       bin_q;
`ifdef DATARAM_MASTER_RMW_EN
    logic [7:0] wdata_q;  // held for the XCHB write phase
    logic [7:0] old_q;    // value read in RD, returned at ack of an RMW op
`endif

    // Request decode, only meaningful in IDLE
    logic       w_bit_op;
    logic       w_is_wr;
    logic       w_reject;
    logic [7:0] w_bit_addr;
    logic [7:0] w_bit_pos;

    assign w_bit_op = (op == c_OP_RDBIT) || (op == c_OP_WRBIT) ||
                      (op == c_OP_SETB)  || (op == c_OP_CLRB)  ||
                      (op == c_OP_CPLB);
    assign w_is_wr  = (op == c_OP_WRB) || (op == c_OP_WRBIT);
`ifdef DATARAM_MASTER_RMW_EN
    assign w_reject = addr[7];
`else
    // Without RMW support ops 1xx are rejected alongside SFR-space accesses
    assign w_reject = addr[7] | op[2];
`endif
    assign w_bit_addr = BIT_BASE + {4'b0000, addr[6:3]};
    assign w_bit_pos  = 8'b0000_0001 << addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= c_OP_RDB;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 8'h00;
            cs_n_q  <= 1'b1;
            rw_q    <= 1'b1;
            bb_q    <= 1'b1;
            addr_q  <= 8'h00;
            pos_q   <= 8'h00;
            din_q   <= 8'h00;
            bin_q   <= 1'b0;
`ifdef DATARAM_MASTER_RMW_EN
            wdata_q <= 8'h00;
            old_q   <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        op_q   <= op;
                        busy_q <= 1'b1;
`ifdef DATARAM_MASTER_RMW_EN
                        wdata_q <= wdata;
`endif
                        if (w_reject) begin
                            // Completed on the accepting edge: ack/err are
                            // visible for the single DONE cycle
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 8'h00;
                            state_q <= S_DONE;
                        end else begin
                            cs_n_q <= 1'b0;
                            bb_q   <= ~w_bit_op;
                            addr_q <= w_bit_op ? w_bit_addr : addr;
                            pos_q  <= w_bit_op ? w_bit_pos : 8'h00;
                            if (w_is_wr) begin
                                rw_q <= 1'b0;
                                if (w_bit_op) begin
                                    bin_q <= wbit;
                                end else begin
                                    din_q <= wdata;
                                end
                                state_q <= S_WR;
                            end else begin
                                rw_q    <= 1'b1;
                                state_q <= S_RD;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (op_q == c_OP_RDB || op_q == c_OP_RDBIT) begin
                        cs_n_q  <= 1'b1;
                        ack_q   <= 1'b1;
                        rdata_q <= (op_q == c_OP_RDB) ? ram_dout
                                                      : {7'b0, ram_bout};
                        state_q <= S_DONE;
                    end else begin
`ifdef DATARAM_MASTER_RMW_EN
                        // Turn the read straight into the write cycle
                        rw_q <= 1'b0;
                        if (op_q == c_OP_XCHB) begin
                            old_q <= ram_dout;
                            din_q <= wdata_q;
                        end else begin
                            old_q <= {7'b0, ram_bout};
                            case (op_q)
                                c_OP_SETB: bin_q <= 1'b1;
                                c_OP_CLRB: bin_q <= 1'b0;
                                default:   bin_q <= ~ram_bout;
                            endcase
                        end
                        state_q <= S_WR;
`else
                        // Unreachable: 1xx ops never leave IDLE here
                        cs_n_q  <= 1'b1;
                        ack_q   <= 1'b1;
                        rdata_q <= 8'h00;
                        state_q <= S_DONE;
`endif
                    end
                end

                S_WR: begin
                    cs_n_q <= 1'b1;
                    rw_q   <= 1'b1;
                    ack_q  <= 1'b1;
`ifdef DATARAM_MASTER_RMW_EN
                    rdata_q <= (op_q == c_OP_WRB || op_q == c_OP_WRBIT)
                               ? 8'h00 : old_q;
`else
                    rdata_q <= 8'h00;
`endif
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    cs_n_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign rdata    = rdata_q;
    assign ram_cs_n = cs_n_q;
    assign ram_rw   = rw_q;
    assign ram_bb   = bb_q;
    assign ram_addr = addr_q;
    assign ram_pos  = pos_q;
    assign ram_din  = din_q;
    assign ram_bin  = bin_q;

endmodule

`default_nettype wire

// File: tb/tb_dataram_master.sv
// ============================================================================
// Module      : tb_dataram_master
// Description : Directed self-checking bench for dataram_master with a
//               behavioural 256-byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dataram_master;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wbit;
    logic       ack;
    logic       err;
    logic       busy;
    logic [7:0] rdata;
    logic       ram_cs_n;
    logic       ram_rw;
    logic       ram_bb;
    logic [7:0] ram_addr;
    logic [7:0] ram_pos;
    logic [7:0] ram_din;
    logic       ram_bin;
    logic [7:0] ram_dout;
    logic       ram_bout;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    int         wr_count = 0;

    dataram_master #(.BIT_BASE(8'h20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .wbit     (wbit),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .rdata    (rdata),
        .ram_cs_n (ram_cs_n),
        .ram_rw   (ram_rw),
        .ram_bb   (ram_bb),
        .ram_addr (ram_addr),
        .ram_pos  (ram_pos),
        .ram_din  (ram_din),
        .ram_bin  (ram_bin),
        .ram_dout (ram_dout),
        .ram_bout (ram_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge
    assign ram_dout = mem[ram_addr];
    assign ram_bout = |(mem[ram_addr] & ram_pos);

    always @(posedge clk) begin
        if (!ram_cs_n && !ram_rw) begin
            wr_count <= wr_count + 1;
            if (ram_bb)
                mem[ram_addr] <= ram_din;
            else if (ram_bin)
                mem[ram_addr] <= mem[ram_addr] | ram_pos;
            else
                mem[ram_addr] <= mem[ram_addr] & ~ram_pos;
        end
    end

    // Issue one request and wait for its ack; lat = negedges after the
    // accepting edge at which ack is seen (0 = never acked).
    task automatic do_op(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] wd, input logic wb,
                         output int lat, output logic e, output logic [7:0] rd,
                         output int csn, output logic [7:0] la,
                         output logic [7:0] lp, output logic lbb,
                         output logic lbin);
        lat = 0; e = 1'b0; rd = 8'h00; csn = 0;
        la = 8'h00; lp = 8'h00; lbb = 1'b1; lbin = 1'b0;
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd; wbit = wb;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!ram_cs_n) begin
                csn++;
                la  = ram_addr;
                lp  = ram_pos;
                lbb = ram_bb;
                if (!ram_rw) lbin = ram_bin;
            end
            if (ack) begin
                lat = i;
                e   = err;
                rd  = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (ram_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", ram_cs_n); end
        total++; if (ram_rw !== 1'b1) begin bad++; $display("FAIL reset_rw got=%b exp=1", ram_rw); end
        total++; if (ram_bb !== 1'b1) begin bad++; $display("FAIL reset_bb got=%b exp=1", ram_bb); end
        total++; if (ram_addr !== 8'h00 || ram_pos !== 8'h00 || ram_din !== 8'h00 || ram_bin !== 1'b0) begin
            bad++; $display("FAIL reset_ram_bus got addr=%h pos=%h din=%h bin=%b exp all 0", ram_addr, ram_pos, ram_din, ram_bin); end
        total++; if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_status got ack=%b err=%b busy=%b exp 0 0 0", ack, err, busy); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    endtask

    task automatic test_byte();
        int lat, csn; logic e, lbb, lbin; logic [7:0] rd, la, lp;
        do_op(3'b001, 8'h30, 8'hA5, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 2) begin bad++; $display("FAIL wrb_latency got=%0d exp=2", lat); end
        total++; if (e !== 1'b0 || rd !== 8'h00) begin bad++; $display("FAIL wrb_result got err=%b rdata=%h exp 0 00", e, rd); end
        total++; if (csn !== 1 || la !== 8'h30 || lbb !== 1'b1) begin
            bad++; $display("FAIL wrb_cycle got cs=%0d addr=%h bb=%b exp 1 30 1", csn, la, lbb); end
        @(negedge clk);
        total++; if (ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wrb_after got ack=%b busy=%b exp 0 0", ack, busy); end
        total++; if (mem[8'h30] !== 8'hA5) begin bad++; $display("FAIL wrb_mem got=%h exp=a5", mem[8'h30]); end
        do_op(3'b000, 8'h30, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 2) begin bad++; $display("FAIL rdb_latency got=%0d exp=2", lat); end
        total++; if (rd !== 8'hA5 || e !== 1'b0) begin bad++; $display("FAIL rdb_rdata got=%h err=%b exp a5 0", rd, e); end
    endtask

    task automatic test_bit();
        int lat, csn; logic e, lbb, lbin; logic [7:0] rd, la, lp;
        do_op(3'b011, 8'h0B, 8'h00, 1'b1, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (la !== 8'h21 || lp !== 8'h08 || lbb !== 1'b0) begin
            bad++; $display("FAIL wrbit_map got addr=%h pos=%h bb=%b exp 21 08 0", la, lp, lbb); end
        total++; if (lat !== 2 || rd !== 8'h00) begin bad++; $display("FAIL wrbit_result got lat=%0d rdata=%h exp 2 00", lat, rd); end
        total++; if (mem[8'h21] !== 8'h08) begin bad++; $display("FAIL wrbit_mem got=%h exp=08", mem[8'h21]); end
        do_op(3'b010, 8'h0B, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (rd !== 8'h01 || lat !== 2) begin bad++; $display("FAIL rdbit_rdata got=%h lat=%0d exp 01 2", rd, lat); end
        do_op(3'b010, 8'h0C, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (rd !== 8'h00 || lp !== 8'h10) begin bad++; $display("FAIL rdbit_zero got rdata=%h pos=%h exp 00 10", rd, lp); end
    endtask

    task automatic test_reject();
        int lat, csn; logic e, lbb, lbin; logic [7:0] rd, la, lp;
        do_op(3'b010, 8'h85, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL rej_bit got lat=%0d err=%b exp 1 1", lat, e); end
        total++; if (csn !== 0 || rd !== 8'h00) begin bad++; $display("FAIL rej_bit_bus got cs=%0d rdata=%h exp 0 00", csn, rd); end
        do_op(3'b001, 8'h90, 8'h55, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 1 || e !== 1'b1 || csn !== 0) begin
            bad++; $display("FAIL rej_byte got lat=%0d err=%b cs=%0d exp 1 1 0", lat, e, csn); end
        @(negedge clk);
        total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rej_after got err=%b busy=%b exp 0 0", err, busy); end
    endtask

    task automatic test_busy_ignore();
        int acks = 0;
        @(negedge clk);
        req = 1'b1; op = 3'b000; addr = 8'h30;
        @(posedge clk);
        @(negedge clk);
        op = 3'b001; addr = 8'h40; wdata = 8'h77;
        @(negedge clk);
        total++; if (ack !== 1'b1 || rdata !== 8'hA5) begin bad++; $display("FAIL busy_first got ack=%b rdata=%h exp 1 a5", ack, rdata); end
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        total++; if (acks !== 0 || mem[8'h40] !== 8'h00) begin
            bad++; $display("FAIL busy_ignore got acks=%0d mem40=%h exp 0 00", acks, mem[8'h40]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; op = 3'b000; addr = 8'h30;
        @(posedge clk);
        @(negedge clk);
        op = 3'b001; addr = 8'h41; wdata = 8'h5A;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL b2b_first_ack got=%b exp=1", ack); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b ack=%b exp 0 0", busy, ack); end
        @(negedge clk);
        req = 1'b0;
        total++; if (ram_cs_n !== 1'b0 || ram_rw !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_wr got cs_n=%b rw=%b busy=%b exp 0 0 1", ram_cs_n, ram_rw, busy); end
        @(negedge clk);
        total++; if (ack !== 1'b1 || mem[8'h41] !== 8'h5A) begin
            bad++; $display("FAIL b2b_second got ack=%b mem41=%h exp 1 5a", ack, mem[8'h41]); end
    endtask

`ifdef DATARAM_MASTER_RMW_EN
    task automatic test_rmw();
        int lat, csn; logic e, lbb, lbin; logic [7:0] rd, la, lp;
        do_op(3'b110, 8'h0B, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 3 || csn !== 2) begin bad++; $display("FAIL cplb_timing got lat=%0d cs=%0d exp 3 2", lat, csn); end
        total++; if (lbin !== 1'b0 || rd !== 8'h01 || e !== 1'b0) begin
            bad++; $display("FAIL cplb_result got bin=%b rdata=%h err=%b exp 0 01 0", lbin, rd, e); end
        total++; if (mem[8'h21] !== 8'h00) begin bad++; $display("FAIL cplb_mem got=%h exp=00", mem[8'h21]); end
        do_op(3'b111, 8'h30, 8'h3C, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (rd !== 8'hA5 || lat !== 3 || mem[8'h30] !== 8'h3C) begin
            bad++; $display("FAIL xchb got rdata=%h lat=%0d mem30=%h exp a5 3 3c", rd, lat, mem[8'h30]); end
        do_op(3'b100, 8'h00, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (rd !== 8'h00 || mem[8'h20] !== 8'h01) begin
            bad++; $display("FAIL setb got rdata=%h mem20=%h exp 00 01", rd, mem[8'h20]); end
        do_op(3'b101, 8'h00, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (rd !== 8'h01 || mem[8'h20] !== 8'h00) begin
            bad++; $display("FAIL clrb got rdata=%h mem20=%h exp 01 00", rd, mem[8'h20]); end
    endtask
`else
    task automatic test_rmw();
        int lat, csn; logic e, lbb, lbin; logic [7:0] rd, la, lp;
        do_op(3'b111, 8'h30, 8'h3C, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 1 || e !== 1'b1 || csn !== 0) begin
            bad++; $display("FAIL xchb_rej got lat=%0d err=%b cs=%0d exp 1 1 0", lat, e, csn); end
        total++; if (mem[8'h30] !== 8'hA5 || rd !== 8'h00) begin
            bad++; $display("FAIL xchb_rej_mem got mem30=%h rdata=%h exp a5 00", mem[8'h30], rd); end
        do_op(3'b100, 8'h0B, 8'h00, 1'b0, lat, e, rd, csn, la, lp, lbb, lbin);
        total++; if (lat !== 1 || e !== 1'b1 || csn !== 0) begin
            bad++; $display("FAIL setb_rej got lat=%0d err=%b cs=%0d exp 1 1 0", lat, e, csn); end
    endtask
`endif

    task automatic test_reset_mid();
        int wc;
        int acks = 0;
        @(negedge clk);
        req = 1'b1;
`ifdef DATARAM_MASTER_RMW_EN
        op = 3'b100; addr = 8'h10;
`else
        op = 3'b000; addr = 8'h30;
`endif
        @(posedge clk);
        #2 req = 1'b0;
        total++; if (ram_cs_n !== 1'b0 || ram_rw !== 1'b1) begin
            bad++; $display("FAIL mid_rd got cs_n=%b rw=%b exp 0 1", ram_cs_n, ram_rw); end
        wc = wr_count;
        rst_n = 1'b0;
        #1;
        total++; if (ram_cs_n !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) begin
            bad++; $display("FAIL mid_reset got cs_n=%b busy=%b ack=%b exp 1 0 0", ram_cs_n, busy, ack); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        total++; if (acks !== 0 || wr_count !== wc || mem[8'h22] !== 8'h00) begin
            bad++; $display("FAIL mid_abort got acks=%0d writes=%0d mem22=%h exp 0 %0d 00", acks, wr_count, mem[8'h22], wc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0; req = 1'b0; op = 3'b000; addr = 8'h00; wdata = 8'h00; wbit = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_byte();
        test_bit();
        test_reject();
        test_busy_ignore();
        test_back_to_back();
        test_rmw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dataram_master.md
DATARAM_MASTER -- requirements
Module: dataram_master

Interface
REQ-001 Parameter: BIT_BASE, default 8'h20, byte address of bit-addressable area start.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  core request, sampled in IDLE only.
REQ-005 op  input  3  000 RDB, 001 WRB, 010 RDBIT, 011 WRBIT, 100 SETB, 101 CLRB, 110 CPLB, 111 XCHB.
REQ-006 addr  input  8  byte address (byte ops) or bit address (bit ops).
REQ-007 wdata  input  8  write byte (WRB, XCHB).
REQ-008 wbit  input  1  write bit (WRBIT).
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 err  output  1  one-cycle pulse coincident with ack on a rejected op.
REQ-011 busy  output  1  high from acceptance through the ack cycle.
REQ-012 rdata  output  8  result, valid when ack=1 and held until next ack.
REQ-013 ram_cs_n  output  1  RAM chip select, active low.
REQ-014 ram_rw  output  1  1 read, 0 write.
REQ-015 ram_bb  output  1  1 byte access, 0 bit access.
REQ-016 ram_addr  output  8  RAM byte address.
REQ-017 ram_pos  output  8  one-hot bit position.
REQ-018 ram_din / ram_bin  output  8 / 1  RAM write byte / write bit.
REQ-019 ram_dout / ram_bout  input  8 / 1  RAM read byte / read bit, combinational from RAM.

Function
REQ-020 FSM states SHALL be IDLE, RD, WR, DONE; all outputs SHALL be registered.
REQ-021 IDLE: ram_cs_n=1, busy=0; on req=1, latch op/addr/wdata/wbit, set busy; next RD for RDB/RDBIT/SETB/CLRB/CPLB/XCHB, WR for WRB/WRBIT, DONE with err for rejects.
REQ-022 Bit ops: ram_addr = BIT_BASE + addr[6:3], ram_pos = 1<<addr[2:0], ram_bb=0; byte ops: ram_addr=addr, ram_pos=0, ram_bb=1.
REQ-023 Reject: bit op with addr[7]=1 (SFR bit space), or byte op with addr[7]=1; no RAM cycle, rdata=0.
REQ-024 RD: ram_cs_n=0, ram_rw=1 for one cycle; ram_dout/ram_bout captured at the end of that cycle; next DONE for RDB/RDBIT, WR for RMW ops.
REQ-025 WR: ram_cs_n=0, ram_rw=0 for one cycle; write value WRB/XCHB=wdata, WRBIT=wbit, SETB=1, CLRB=0, CPLB=~captured bit; next DONE.
REQ-026 DONE: ack=1 for one cycle, ram_cs_n=1; next IDLE.
REQ-027 rdata: RDB/XCHB = byte read; RDBIT/SETB/CLRB/CPLB = {7'b0, old bit}; WRB/WRBIT = 8'h00.
REQ-028 Latency from accepting edge to ack high: 2 cycles (single access), 3 cycles (RMW), 1 cycle (reject).
REQ-029 req while busy SHALL be ignored, not queued; back-to-back: next req accepted in the cycle after DONE.
REQ-030 ram_cs_n SHALL never be low for more than one cycle per access or outside RD/WR.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, ram_cs_n=1, ram_rw=1, ram_bb=1, ram_addr=0, ram_pos=0, ram_din=0, ram_bin=0, ack=0, err=0, busy=0, rdata=0.
REQ-032 Reset mid-RMW SHALL abort without a write cycle; no ack issued for the aborted op.

Configuration
REQ-033 Macro DATARAM_MASTER_RMW_EN: defined, ops 100-111 execute as above; undefined, ops 100-111 are rejects per REQ-023 (ack+err, 1-cycle latency) and the RD->WR path is absent.

Verification
REQ-034 WRB addr=8'h30 wdata=8'hA5, then RDB addr=8'h30 -> rdata=8'hA5, ack 2 cycles after acceptance each.
REQ-035 WRBIT addr=8'h0B wbit=1 -> ram_addr=8'h21, ram_pos=8'h08, ram_bb=0; RDBIT 8'h0B -> rdata=8'h01.
REQ-036 CPLB addr=8'h0B (bit=1) -> RD then WR cycle, ram_bin=0, rdata=8'h01, ack 3 cycles after acceptance.
REQ-037 RDBIT addr=8'h85 -> ack+err 1 cycle after acceptance, ram_cs_n stays 1, rdata=8'h00.
REQ-038 rst_n low during RD of SETB -> ram_cs_n=1 same cycle, no write, no ack, busy=0.
REQ-039 Without DATARAM_MASTER_RMW_EN: XCHB addr=8'h30 -> ack+err, 8'h30 contents unchanged.
